instr_fetch: RTL



---
 rtl/instr_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch -- sequential instruction-fetch unit for the MIPS core.
//
// Owns the PC, runs a req/ack handshake with instruction memory, and holds
// each fetched word stable for the control decoder until it is consumed.
//
// Parameters:
//   RESET_PC            PC loaded on reset (word-aligned).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req_o          fetch request (high in FETCH, low during reset)
//   imem_addr_o         fetch address (== pc_o)
//   imem_ack_i          memory data valid this cycle
//   imem_data_i         instruction word, taken on req && ack
//   stall_i             downstream cannot take the held instruction
//   redirect_i          jump/taken branch: next PC is redirect_pc_i
//   redirect_pc_i       redirect target
//   instr_valid_o       instr_o and derived fields are valid (HOLD)
//   instr_o             held instruction word
//   instr_op_ctl_o      instr_o[31:26]
//   instr_funct_ctl_o   instr_o[5:0]
//   pc_o, pc_plus4_o    current PC and PC+4 (mod 2^32)
//   instr_count_o       consumed-instruction count (wraps)
//   fault_o             sticky misaligned-redirect fault
//
// Build option:
//   INSTR_FETCH_ALIGN_CHECK_EN  when defined, a consuming redirect to a
//   non-word-aligned target enters a terminal FAULT state. When undefined,
//   the low two target bits are forced to zero and fault_o is tied low.

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_ctl_o,
  output logic [5:0]  instr_funct_ctl_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_count_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        redirect_misaligned;
  logic        fetch_done;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  assign redirect_tgt        = redirect_pc_i;
  assign redirect_misaligned = redirect_i & (|redirect_pc_i[1:0]);
  // FAULT is terminal until reset, so the state itself is the sticky flag.
  assign fault_o             = (state_q == S_FAULT);
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign redirect_tgt         = {redirect_pc_i[31:2], 2'b00};
  assign redirect_misaligned  = 1'b0;
  assign fault_o              = 1'b0;
`endif

  // The request is masked during reset so an outstanding fetch is
  // abandoned in the reset cycle itself; any ack arriving then is ignored.
  assign imem_req_o  = (state_q == S_FETCH) && !reset;
  assign imem_addr_o = pc_q;
  assign fetch_done  = imem_req_o && imem_ack_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          instr_d = imem_data_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          count_d = count_q + 32'd1;
          pc_d    = redirect_i ? redirect_tgt : pc_plus4;
          state_d = redirect_misaligned ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign instr_valid_o     = (state_q == S_HOLD);
  assign instr_o           = instr_q;
  assign instr_op_ctl_o    = instr_q[31:26];
  assign instr_funct_ctl_o = instr_q[5:0];
  assign pc_o              = pc_q;
  assign pc_plus4_o        = pc_plus4;
  assign instr_count_o     = count_q;

endmodule
